// File: rtl/mx4_rr_arbiter.sv
// Packet-level round-robin arbiter sharing one 4:1 mux datapath between
// four streaming requesters. The grant is held for a whole packet.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid[3:0]     per-requester valid (bit i = requester i)
//   in_last[3:0]      per-requester end-of-packet, qualified by in_valid[i]
//   in_data           requester i at [i*DATA_W +: DATA_W]
//   in_ready[3:0]     per-requester ready (only the granted bit can be set)
//   out_valid/last/data  shared output channel, routed from requester sel
//   out_ready         consumer ready
//   sel[1:0]          registered grant index driving S1:S0 of the shared mux
//   busy              high while a packet is granted
module mx4_rr_arbiter #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            in_valid,
    input  logic [3:0]            in_last,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_W-1:0]     out_data,
    input  logic                  out_ready,
    output logic [1:0]            sel,
    output logic                  busy
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   last_grant_q, last_grant_d;

    logic               arb_hit;
    logic [SEL_W-1:0]   arb_idx;
    logic [SEL_W-1:0]   cand;
    logic               xfer;
    logic               beat_last;
    logic [DATA_W-1:0]  data_arr [N_REQ];

    // Unpack the flat data bus into per-requester lanes
    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign data_arr[i] = in_data[i*DATA_W +: DATA_W];
    end

    // Round-robin pick: first valid requester after last_grant, wrapping
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = last_grant_q;
        cand    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = last_grant_q + SEL_W'(k);
            if (!arb_hit && in_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Output routing follows the held grant; idle state blocks every handshake
    always_comb begin
        xfer      = (state_q == XFER);
        out_valid = xfer & in_valid[sel_q];
        out_last  = xfer & in_last[sel_q];
        out_data  = data_arr[sel_q];
        in_ready  = '0;
        if (xfer) begin
            in_ready[sel_q] = out_ready;
        end
        beat_last = out_valid & out_ready & in_last[sel_q];
        sel       = sel_q;
        busy      = xfer;
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    sel_d   = arb_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (beat_last) begin
                    last_grant_d = sel_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last_grant resets to 3 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= SEL_W'(3);
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_mx4_rr_arbiter.sv
// Self-checking bench for mx4_rr_arbiter (DATA_W=16). Per-cycle vectors are
// driven after each rising edge; expected outputs are queued and compared by
// a monitor on the falling edge. Asynchronous reset is checked by hand.
module tb_mx4_rr_arbiter;

    localparam int unsigned DATA_W = 16;

    logic                clk;
    logic                rst_n;
    logic [3:0]          in_valid;
    logic [3:0]          in_last;
    logic [4*DATA_W-1:0] in_data;
    logic [3:0]          in_ready;
    logic                out_valid;
    logic                out_last;
    logic [DATA_W-1:0]   out_data;
    logic                out_ready;
    logic [1:0]          sel;
    logic                busy;

    int checks   = 0;
    int failures = 0;

    mx4_rr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                rst;
        logic [3:0]          v;
        logic [3:0]          l;
        logic [4*DATA_W-1:0] d;
        logic                ordy;
        logic [1:0]          e_sel;
        logic                e_busy;
        logic                e_ov;
        logic                e_ol;
        logic [DATA_W-1:0]   e_od;
        logic [3:0]          e_ir;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];
    vec_t mon_e;
    int   mon_idx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                                input logic [15:0] d3, input logic [15:0] d2,
                                input logic [15:0] d1, input logic [15:0] d0,
                                input logic ordy, input logic [1:0] esel, input logic ebusy,
                                input logic eov, input logic eol, input logic [15:0] eod,
                                input logic [3:0] eir);
        vec_t r;
        r.rst = rst; r.v = v; r.l = l; r.d = {d3, d2, d1, d0}; r.ordy = ordy;
        r.e_sel = esel; r.e_busy = ebusy; r.e_ov = eov; r.e_ol = eol;
        r.e_od = eod; r.e_ir = eir;
        return r;
    endfunction

    // Scoreboard monitor: compares the oldest queued expectation each falling edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk($sformatf("v%0d.sel", mon_idx),      32'(sel),       32'(mon_e.e_sel));
            chk($sformatf("v%0d.busy", mon_idx),     32'(busy),      32'(mon_e.e_busy));
            chk($sformatf("v%0d.out_valid", mon_idx), 32'(out_valid), 32'(mon_e.e_ov));
            chk($sformatf("v%0d.out_last", mon_idx), 32'(out_last),  32'(mon_e.e_ol));
            chk($sformatf("v%0d.out_data", mon_idx), 32'(out_data),  32'(mon_e.e_od));
            chk($sformatf("v%0d.in_ready", mon_idx), 32'(in_ready),  32'(mon_e.e_ir));
            mon_idx++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- all four valid, 1-beat packets: grants 0,1,2,3,0 with one IDLE between
        vecs.push_back(mk(1, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 0, 0, 0, 0, 16'hD0D0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 0, 1, 1, 1, 16'hD0D0, 4'h1));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 0, 0, 0, 0, 16'hD0D0, 4'h0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 1, 1, 1, 1, 16'hD1D1, 4'h2));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 1, 0, 0, 0, 16'hD1D1, 4'h0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 2, 1, 1, 1, 16'hD2D2, 4'h4));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 2, 0, 0, 0, 16'hD2D2, 4'h0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 3, 1, 1, 1, 16'hD3D3, 4'h8));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 3, 0, 0, 0, 16'hD3D3, 4'h0));
        vecs.push_back(mk(0, 4'hF, 4'hF, 16'hD3D3, 16'hD2D2, 16'hD1D1, 16'hD0D0, 1, 0, 1, 1, 1, 16'hD0D0, 4'h1));
        // ---- requester 2 only, 3-beat packet A1,A2,A3
        vecs.push_back(mk(1, 4'h4, 4'h0, 16'h0, 16'h00A1, 16'h0, 16'h0, 1, 0, 0, 0, 0, 16'h0000, 4'h0));
        vecs.push_back(mk(0, 4'h4, 4'h0, 16'h0, 16'h00A1, 16'h0, 16'h0, 1, 2, 1, 1, 0, 16'h00A1, 4'h4));
        vecs.push_back(mk(0, 4'h4, 4'h0, 16'h0, 16'h00A2, 16'h0, 16'h0, 1, 2, 1, 1, 0, 16'h00A2, 4'h4));
        vecs.push_back(mk(0, 4'h4, 4'h4, 16'h0, 16'h00A3, 16'h0, 16'h0, 1, 2, 1, 1, 1, 16'h00A3, 4'h4));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'h0, 16'h00A3, 16'h0, 16'h0, 1, 2, 0, 0, 0, 16'h00A3, 4'h0));
        // ---- requester 1 with stalls and valid gap; requester 3 waiting throughout
        vecs.push_back(mk(1, 4'hA, 4'h8, 16'h3333, 16'h0, 16'h00B1, 16'h0, 1, 0, 0, 0, 0, 16'h0000, 4'h0));
        vecs.push_back(mk(0, 4'hA, 4'h8, 16'h3333, 16'h0, 16'h00B1, 16'h0, 1, 1, 1, 1, 0, 16'h00B1, 4'h2));
        vecs.push_back(mk(0, 4'hA, 4'h8, 16'h3333, 16'h0, 16'h00B2, 16'h0, 0, 1, 1, 1, 0, 16'h00B2, 4'h0));
        vecs.push_back(mk(0, 4'hA, 4'h8, 16'h3333, 16'h0, 16'h00B2, 16'h0, 1, 1, 1, 1, 0, 16'h00B2, 4'h2));
        vecs.push_back(mk(0, 4'h8, 4'h8, 16'h3333, 16'h0, 16'h00B2, 16'h0, 1, 1, 1, 0, 0, 16'h00B2, 4'h2));
        vecs.push_back(mk(0, 4'h8, 4'h8, 16'h3333, 16'h0, 16'h00B2, 16'h0, 1, 1, 1, 0, 0, 16'h00B2, 4'h2));
        vecs.push_back(mk(0, 4'hA, 4'hA, 16'h3333, 16'h0, 16'h00B3, 16'h0, 1, 1, 1, 1, 1, 16'h00B3, 4'h2));
        vecs.push_back(mk(0, 4'h8, 4'h8, 16'h3333, 16'h0, 16'h00B3, 16'h0, 1, 1, 0, 0, 0, 16'h00B3, 4'h0));
        vecs.push_back(mk(0, 4'h8, 4'h8, 16'h3333, 16'h0, 16'h00B3, 16'h0, 1, 3, 1, 1, 1, 16'h3333, 4'h8));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'h3333, 16'h0, 16'h00B3, 16'h0, 1, 3, 0, 0, 0, 16'h3333, 4'h0));
        // ---- last_grant=3, requesters 0 and 3 continuous: 0,3,0 alternation
        vecs.push_back(mk(0, 4'h9, 4'h9, 16'h3C3C, 16'h0, 16'h0, 16'h0C0C, 1, 3, 0, 0, 0, 16'h3C3C, 4'h0));
        vecs.push_back(mk(0, 4'h9, 4'h9, 16'h3C3C, 16'h0, 16'h0, 16'h0C0C, 1, 0, 1, 1, 1, 16'h0C0C, 4'h1));
        vecs.push_back(mk(0, 4'h9, 4'h9, 16'h3C3C, 16'h0, 16'h0, 16'h0C0C, 1, 0, 0, 0, 0, 16'h0C0C, 4'h0));
        vecs.push_back(mk(0, 4'h9, 4'h9, 16'h3C3C, 16'h0, 16'h0, 16'h0C0C, 1, 3, 1, 1, 1, 16'h3C3C, 4'h8));
        vecs.push_back(mk(0, 4'h9, 4'h9, 16'h3C3C, 16'h0, 16'h0, 16'h0C0C, 1, 3, 0, 0, 0, 16'h3C3C, 4'h0));
        vecs.push_back(mk(0, 4'h9, 4'h9, 16'h3C3C, 16'h0, 16'h0, 16'h0C0C, 1, 0, 1, 1, 1, 16'h0C0C, 4'h1));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'h3C3C, 16'h0, 16'h0, 16'h0C0C, 1, 0, 0, 0, 0, 16'h0C0C, 4'h0));
        // ---- requester 3 single beat 0xBEEF, out_ready low 4 cycles
        vecs.push_back(mk(1, 4'h8, 4'h8, 16'hBEEF, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 16'h0000, 4'h0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 4'h8, 4'h8, 16'hBEEF, 16'h0, 16'h0, 16'h0, 0, 3, 1, 1, 1, 16'hBEEF, 4'h0));
        vecs.push_back(mk(0, 4'h8, 4'h8, 16'hBEEF, 16'h0, 16'h0, 16'h0, 1, 3, 1, 1, 1, 16'hBEEF, 4'h8));
        vecs.push_back(mk(0, 4'h0, 4'h0, 16'hBEEF, 16'h0, 16'h0, 16'h0, 1, 3, 0, 0, 0, 16'hBEEF, 4'h0));

        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        // Reset state with inputs idle
        chk("reset.busy",      32'(busy),      32'h0);
        chk("reset.sel",       32'(sel),       32'h0);
        chk("reset.out_valid", 32'(out_valid), 32'h0);
        chk("reset.in_ready",  32'(in_ready),  32'h0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            if (vecs[i].rst) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            in_valid  = vecs[i].v;
            in_last   = vecs[i].l;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            sb_q.push_back(vecs[i]);
        end
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
        chk("scoreboard.drained", 32'(sb_q.size()), 32'h0);

        // ---- asynchronous reset mid-beat of requester 2
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        in_valid  = 4'b0100;
        in_last   = 4'b0000;
        in_data   = {16'h0, 16'h00C1, 32'h0};
        out_ready = 1'b1;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("async.pre.busy",      32'(busy),      32'h1);
        chk("async.pre.sel",       32'(sel),       32'h2);
        chk("async.pre.out_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.out_valid", 32'(out_valid), 32'h0);
        chk("async.in_ready",  32'(in_ready),  32'h0);
        chk("async.busy",      32'(busy),      32'h0);
        chk("async.sel",       32'(sel),       32'h0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("async.regrant2.sel",  32'(sel),  32'h2);
        chk("async.regrant2.busy", 32'(busy), 32'h1);
        rst_n    = 1'b0;
        in_valid = 4'b0101;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("async.regrant0.sel",  32'(sel),  32'h0);
        chk("async.regrant0.busy", 32'(busy), 32'h1);
        in_valid = 4'b0000;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mx4_rr_arbiter.md
Name: mx4_rr_arbiter

Overview:
- Packet-level round-robin arbiter that shares one 4:1 mux datapath between four streaming requesters.
- Registers the 2-bit select (`sel[0]` drives S0, `sel[1]` drives S1 of the downstream 4:1 mux), steers the selected requester's valid/data/last to a single output channel, and routes `out_ready` back to that requester.
- Sits between four producer ports and one shared consumer; the grant is held for a whole packet.

Parameters:
- DATA_W, 8, width of each requester's data word and of `out_data`.

Ports:
- clk  input  1  rising-edge clock, only clock of the block
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  4  per-requester valid; bit i = requester i
- in_last  input  4  per-requester end-of-packet flag, qualified by in_valid[i]
- in_data  input  4*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W]
- in_ready  output  4  per-requester ready
- out_valid  output  1  output channel valid
- out_last  output  1  output end-of-packet flag
- out_data  output  DATA_W  output data
- out_ready  input  1  consumer ready
- sel  output  2  current grant index; sel[0]=S0, sel[1]=S1 of the shared mux
- busy  output  1  high while a packet is granted (state XFER)

Behaviour:
- Reset (async, rst_n=0), all taking effect immediately:
  - state=IDLE, sel=2'd0, last_grant=2'd3 (requester 0 has top priority after reset), busy=0.
  - out_valid=0, out_last=0, in_ready=4'b0000.
  - out_data is don't-care but must be driven; implement as in_data[sel].
- Reset asserted mid-packet aborts the packet at once; no beat is completed after rst_n falls. After release, arbitration restarts from last_grant=3.
- State IDLE:
  - out_valid=0, in_ready=0, busy=0; sel holds its previous value.
  - If any in_valid bit is set at a clock edge: pick the first set bit searching last_grant+1, +2, +3, +4 (mod 4). Register it into sel and go to XFER.
  - Arbitration latency: exactly 1 cycle from request visible in IDLE to out_valid possible.
- State XFER:
  - busy=1; sel is stable for the entire packet.
  - Combinational routing: out_valid=in_valid[sel], out_last=in_last[sel], out_data=in_data[sel].
  - in_ready[sel]=out_ready; all other in_ready bits=0.
  - A beat transfers when out_valid && out_ready.
  - On a beat with out_last=1: last_grant<=sel, state<=IDLE.
  - Beats without last keep XFER.
- Boundary conditions:
  - Granted requester drops in_valid mid-packet: grant is held, out_valid=0, wait indefinitely.
  - Other requesters asserting valid during XFER are ignored until the next IDLE cycle.
  - Single-beat packet (last on first beat): XFER lasts 1 cycle when out_ready=1.
  - Between packets there is always exactly one IDLE cycle (no back-to-back grant).
  - Same requester requesting continuously while others wait: it cannot win twice in a row while another requester is valid in IDLE.
  - All four valid in IDLE: winner is last_grant+1 mod 4; wrap from 3 to 0.
  - in_last and in_data of non-granted requesters have no effect.
  - out_ready=0 stalls: no state change, sel held.

Test Plan:
- Reset, then in_valid=4'b1111 with 1-beat packets and out_ready=1 -> grants in order sel=0,1,2,3,0; each out_valid pulse is followed by one IDLE cycle; in_ready one-hot matches sel.
- After reset, only requester 2 sends 3-beat packet data 0xA1,0xA2,0xA3 (last on 3rd) -> sel=2, busy high 3 cycles, out_data sequence A1,A2,A3, out_last only on A3, in_ready=4'b0100 during XFER.
- Requester 1 mid-packet with out_ready toggling 1,0,1 and in_valid[1] dropping for 2 cycles -> sel stays 1, no beat lost or duplicated, requester 3 valid throughout not granted until packet ends, then sel=3.
- last_grant=3, requesters 0 and 3 both valid and requester 3 re-requesting continuously -> next grants 0 then 3 then 0 (alternation, no starvation).
- rst_n pulsed low asynchronously mid-beat of requester 2 -> out_valid, in_ready, busy go 0 before the next clk edge; sel=0; next arbitration with in_valid=4'b0100 grants 2, with 4'b0101 grants 0.
- DATA_W=16, requester 3 data 0xBEEF single beat, out_ready held 0 for 4 cycles then 1 -> out_data=0xBEEF stable and out_valid=1 for 5 cycles; transfer on 5th; IDLE next.
